// File: rtl/riscv_mem_arbiter_if.sv
// Purpose: bundles the fetch, load/store and memory-side signals of the arbiter.
// Latency: none, wiring only.
// Backpressure: requesters hold req until their done pulse; the memory stalls via mem_ready_i.
// Ports: slave = arbiter view, master = core + memory view (used by the bench).
interface riscv_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch port
    logic              inst_req_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              inst_done_o;
    logic [DATA_W-1:0] inst_data_o;
    // load/store port
    logic              data_req_i;
    logic              data_we_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [DATA_W-1:0] data_wdata_i;
    logic              data_done_o;
    logic [DATA_W-1:0] data_rdata_o;
    logic              err_o;
    // memory macro
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;

    modport slave (
        input  inst_req_i, inst_addr_i,
        input  data_req_i, data_we_i, data_addr_i, data_wdata_i,
        input  mem_rdata_i, mem_ready_i,
        output inst_done_o, inst_data_o,
        output data_done_o, data_rdata_o, err_o,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output inst_req_i, inst_addr_i,
        output data_req_i, data_we_i, data_addr_i, data_wdata_i,
        output mem_rdata_i, mem_ready_i,
        input  inst_done_o, inst_data_o,
        input  data_done_o, data_rdata_o, err_o,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Purpose: shares one single-port memory between instruction fetch and load/store,
//          data first, with a fetch starvation guard and a per-access timeout.
// Latency: grant edge N -> mem_ce_o from cycle N+1; mem_ready_i at edge N+k -> done in N+k+1.
// Backpressure: one access in flight; requesters hold req until done, memory stalls with mem_ready_i.
// Ports: clk, rst (async active-low), bus (slave modport of riscv_mem_arbiter_if).
module riscv_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    riscv_mem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] INST_BUSY = 2'd1;
    localparam logic [1:0] DATA_BUSY = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam bit         TO_EN      = (TIMEOUT != 0);
    // last to_cnt value before abort; unused when the timeout is disabled
    localparam logic [7:0] TO_LAST    = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [3:0]        starve_cnt;
    logic [7:0]        to_cnt;

    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              inst_done;
    logic [DATA_W-1:0] inst_data;
    logic              data_done;
    logic [DATA_W-1:0] data_rdata;
    logic              err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            to_cnt     <= '0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_done  <= 1'b0;
            inst_data  <= '0;
            data_done  <= 1'b0;
            data_rdata <= '0;
            err        <= 1'b0;
        end else begin
            // done/err are single-cycle pulses
            inst_done <= 1'b0;
            data_done <= 1'b0;
            err       <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.inst_req_i && (starve_cnt == STARVE_LIM)) begin
                        // fetch has waited through STARVE_MAX data grants
                        state      <= INST_BUSY;
                        starve_cnt <= '0;
                        to_cnt     <= '0;
                        mem_ce     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= bus.inst_addr_i;
                        mem_wdata  <= '0;
                    end else if (bus.data_req_i) begin
                        state  <= DATA_BUSY;
                        to_cnt <= '0;
                        if (bus.inst_req_i) begin
                            if (starve_cnt != STARVE_LIM) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                        mem_ce    <= 1'b1;
                        mem_we    <= bus.data_we_i;
                        mem_addr  <= bus.data_addr_i;
                        mem_wdata <= bus.data_wdata_i;
                    end else if (bus.inst_req_i) begin
                        state      <= INST_BUSY;
                        starve_cnt <= '0;
                        to_cnt     <= '0;
                        mem_ce     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= bus.inst_addr_i;
                        mem_wdata  <= '0;
                    end
                end

                INST_BUSY, DATA_BUSY: begin
                    // mem_* stay frozen here regardless of requester inputs
                    if (bus.mem_ready_i) begin
                        state  <= IDLE;
                        mem_ce <= 1'b0;
                        mem_we <= 1'b0;
                        if (state == INST_BUSY) begin
                            inst_done <= 1'b1;
                            inst_data <= bus.mem_rdata_i;
                        end else begin
                            data_done <= 1'b1;
                            if (!mem_we) begin
                                data_rdata <= bus.mem_rdata_i;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                        if (TO_EN && (to_cnt == TO_LAST)) begin
                            state  <= IDLE;
                            mem_ce <= 1'b0;
                            mem_we <= 1'b0;
                            err    <= 1'b1;
                            if (state == INST_BUSY) begin
                                inst_done <= 1'b1;
                                inst_data <= '0;
                            end else begin
                                data_done <= 1'b1;
                                if (!mem_we) begin
                                    data_rdata <= '0;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    mem_ce <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_ce_o     = mem_ce;
    assign bus.mem_we_o     = mem_we;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_wdata_o  = mem_wdata;
    assign bus.inst_done_o  = inst_done;
    assign bus.inst_data_o  = inst_data;
    assign bus.data_done_o  = data_done;
    assign bus.data_rdata_o = data_rdata;
    assign bus.err_o        = err;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] shadow [logic [31:0]];

    riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    riscv_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic idle_inputs();
        bus.inst_req_i   = 1'b0;
        bus.inst_addr_i  = '0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_addr_i  = '0;
        bus.data_wdata_i = '0;
        bus.mem_rdata_i  = '0;
        bus.mem_ready_i  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.mem_ce_o, bus.mem_we_o} !== 2'b00) begin
            bad++; $display("FAIL reset_ce_we: got %b want 00", {bus.mem_ce_o, bus.mem_we_o});
        end
        total++;
        if ({bus.mem_addr_o, bus.mem_wdata_o} !== 64'd0) begin
            bad++; $display("FAIL reset_addr_wdata: got %h want 0", {bus.mem_addr_o, bus.mem_wdata_o});
        end
        total++;
        if ({bus.inst_done_o, bus.data_done_o, bus.err_o} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses: got %b want 000", {bus.inst_done_o, bus.data_done_o, bus.err_o});
        end
        total++;
        if ({bus.inst_data_o, bus.data_rdata_o} !== 64'd0) begin
            bad++; $display("FAIL reset_rdata: got %h want 0", {bus.inst_data_o, bus.data_rdata_o});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.mem_ce_o !== 1'b0) begin
            bad++; $display("FAIL reset_idle_ce: got %b want 0", bus.mem_ce_o);
        end
    endtask

    task automatic test_single_load();
        int ce_n = 0;
        int done_n = 0;
        logic [31:0] got = '0;
        idle_inputs();
        bus.data_req_i  = 1'b1;
        bus.data_addr_i = 32'h100;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.mem_ce_o) begin
                ce_n++;
                if (ce_n == 1) begin
                    total++;
                    if ({bus.mem_addr_o, bus.mem_we_o} !== {32'h100, 1'b0}) begin
                        bad++; $display("FAIL load_addr: got %h/%b want 100/0", bus.mem_addr_o, bus.mem_we_o);
                    end
                end
            end
            if (bus.data_done_o) begin
                done_n++;
                got = bus.data_rdata_o;
                bus.data_req_i = 1'b0;
            end
            if (bus.mem_ce_o && ce_n == 2) begin
                bus.mem_ready_i = 1'b1;
                bus.mem_rdata_i = 32'hDEAD_BEEF;
            end else begin
                bus.mem_ready_i = 1'b0;
                bus.mem_rdata_i = '0;
            end
        end
        total++;
        if (ce_n !== 2) begin bad++; $display("FAIL load_ce_cycles: got %0d want 2", ce_n); end
        total++;
        if (done_n !== 1) begin bad++; $display("FAIL load_done_count: got %0d want 1", done_n); end
        total++;
        if (got !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata: got %h want deadbeef", got); end
    endtask

    task automatic test_store();
        int ce_n = 0;
        int done_n = 0;
        idle_inputs();
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_addr_i  = 32'h20;
        bus.data_wdata_i = 32'h1234_5678;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.mem_ce_o) begin
                ce_n++;
                total++;
                if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 32'h20, 32'h1234_5678}) begin
                    bad++; $display("FAIL store_hold: got %b/%h/%h want 1/20/12345678",
                                    bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
                end
                // later changes of the requester must not reach the memory
                bus.data_wdata_i = 32'hFFFF_0000;
            end
            if (bus.data_done_o) begin
                done_n++;
                bus.data_req_i = 1'b0;
                total++;
                if ({bus.mem_we_o, bus.data_rdata_o} !== {1'b0, 32'hDEAD_BEEF}) begin
                    bad++; $display("FAIL store_done_state: got we=%b rdata=%h want 0/deadbeef",
                                    bus.mem_we_o, bus.data_rdata_o);
                end
            end
            bus.mem_ready_i = bus.mem_ce_o && (ce_n == 3);
            bus.mem_rdata_i = 32'hBAD0_BAD0;
        end
        total++;
        if (ce_n !== 3) begin bad++; $display("FAIL store_ce_cycles: got %0d want 3", ce_n); end
        total++;
        if (done_n !== 1) begin bad++; $display("FAIL store_done_count: got %0d want 1", done_n); end
        total++;
        if (bus.data_rdata_o !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL store_rdata_kept: got %h want deadbeef", bus.data_rdata_o);
        end
    endtask

    task automatic test_priority();
        int   grants = 0;
        logic ce_prev = 1'b0;
        logic [31:0] exp_addr;
        idle_inputs();
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h300;
        bus.data_req_i  = 1'b1;
        bus.data_addr_i = 32'h400;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            total++;
            if (bus.inst_done_o && bus.data_done_o) begin
                bad++; $display("FAIL prio_both_done: got 11 want at most one");
            end
            if (bus.inst_done_o) begin
                total++;
                if (bus.inst_data_o !== 32'h5A5A_0300) begin
                    bad++; $display("FAIL prio_inst_data: got %h want 5a5a0300", bus.inst_data_o);
                end
            end
            if (bus.mem_ce_o && !ce_prev) begin
                if (grants < 10) begin
                    exp_addr = (grants % 5 == 4) ? 32'h300 : 32'h400;
                    total++;
                    if (bus.mem_addr_o !== exp_addr) begin
                        bad++; $display("FAIL prio_order grant %0d: got %h want %h", grants, bus.mem_addr_o, exp_addr);
                    end
                end
                grants++;
                if (grants == 10) begin
                    bus.inst_req_i = 1'b0;
                    bus.data_req_i = 1'b0;
                end
            end
            bus.mem_ready_i = bus.mem_ce_o;
            bus.mem_rdata_i = bus.mem_addr_o ^ 32'h5A5A_0000;
            ce_prev = bus.mem_ce_o;
        end
        total++;
        if (grants !== 10) begin bad++; $display("FAIL prio_grant_count: got %0d want 10", grants); end
    endtask

    task automatic test_timeout();
        int ce_n = 0;
        int done_n = 0;
        int err_n = 0;
        logic [31:0] got = 32'hFFFF_FFFF;
        idle_inputs();
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h40;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mem_ce_o) ce_n++;
            total++;
            if (bus.err_o && !bus.inst_done_o) begin
                bad++; $display("FAIL to_err_alone: got err=1 done=0 want err only with done");
            end
            if (bus.inst_done_o) begin
                done_n++;
                if (bus.err_o) err_n++;
                got = bus.inst_data_o;
                bus.inst_req_i = 1'b0;
            end
        end
        total++;
        if (ce_n !== 8) begin bad++; $display("FAIL to_ce_cycles: got %0d want 8", ce_n); end
        total++;
        if ({done_n, err_n} !== {32'd1, 32'd1}) begin
            bad++; $display("FAIL to_pulses: got done=%0d err=%0d want 1/1", done_n, err_n);
        end
        total++;
        if (got !== 32'd0) begin bad++; $display("FAIL to_inst_data: got %h want 0", got); end
        total++;
        if (bus.data_done_o !== 1'b0 || bus.mem_ce_o !== 1'b0) begin
            bad++; $display("FAIL to_idle: got ce=%b want 0", bus.mem_ce_o);
        end
    endtask

    task automatic test_reset_mid_access();
        idle_inputs();
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h500;
        bus.data_req_i  = 1'b1;
        bus.data_addr_i = 32'h600;
        @(negedge clk);
        total++;
        if ({bus.mem_ce_o, bus.mem_addr_o} !== {1'b1, 32'h600}) begin
            bad++; $display("FAIL rstmid_grant: got %b/%h want 1/600", bus.mem_ce_o, bus.mem_addr_o);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (bus.mem_ce_o !== 1'b0) begin bad++; $display("FAIL rstmid_ce_drop: got %b want 0", bus.mem_ce_o); end
        bus.data_req_i = 1'b0;
        @(negedge clk);
        total++;
        if (bus.data_done_o !== 1'b0) begin bad++; $display("FAIL rstmid_no_done: got %b want 0", bus.data_done_o); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o} !== {2'b10, 32'h500}) begin
            bad++; $display("FAIL rstmid_inst_first: got %b/%b/%h want 1/0/500",
                            bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o);
        end
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        bus.inst_req_i  = 1'b0;
        total++;
        if ({bus.inst_done_o, bus.data_done_o, bus.inst_data_o} !== {2'b10, 32'h0BAD_F00D}) begin
            bad++; $display("FAIL rstmid_fetch_done: got %b%b/%h want 10/0badf00d",
                            bus.inst_done_o, bus.data_done_o, bus.inst_data_o);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_req_drop();
        int ce_n = 0;
        int done_n = 0;
        idle_inputs();
        bus.data_req_i  = 1'b1;
        bus.data_addr_i = 32'h200;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.mem_ce_o) begin
                ce_n++;
                bus.data_req_i = 1'b0;
            end
            if (bus.data_done_o) begin
                done_n++;
                total++;
                if (bus.data_rdata_o !== 32'hCAFE_F00D) begin
                    bad++; $display("FAIL drop_rdata: got %h want cafef00d", bus.data_rdata_o);
                end
            end
            bus.mem_ready_i = bus.mem_ce_o && (ce_n == 3);
            bus.mem_rdata_i = 32'hCAFE_F00D;
        end
        total++;
        if ({ce_n, done_n} !== {32'd3, 32'd1}) begin
            bad++; $display("FAIL drop_counts: got ce=%0d done=%0d want 3/1", ce_n, done_n);
        end
    endtask

    task automatic test_random();
        logic ip = 0, dp = 0, dwe = 0, ce_prev = 0, rdy_prev = 0, rdy;
        logic [31:0] ia = 0, da = 0, dwd = 0;
        int   owner = 0;        // 0 none, 1 fetch, 2 data
        logic [31:0] o_addr = 0, o_wd = 0;
        logic o_we = 0;
        int   streak = 0, waitc = 0, gi = 0, gd = 0, exp_win;
        idle_inputs();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            total++;
            if ({bus.inst_done_o, bus.data_done_o, bus.err_o} !==
                {rdy_prev && owner == 1, rdy_prev && owner == 2, 1'b0}) begin
                bad++; $display("FAIL rand_pulses cyc %0d: got %b%b%b want %b%b0", cyc,
                                bus.inst_done_o, bus.data_done_o, bus.err_o,
                                rdy_prev && owner == 1, rdy_prev && owner == 2);
            end
            total++;
            if (ce_prev && !bus.mem_ce_o && !rdy_prev) begin
                bad++; $display("FAIL rand_ce_drop cyc %0d: got ce=0 want 1", cyc);
            end
            if (rdy_prev) begin
                if (owner == 1) begin
                    total++;
                    if (bus.inst_data_o !== mem_val(o_addr)) begin
                        bad++; $display("FAIL rand_inst_data: got %h want %h", bus.inst_data_o, mem_val(o_addr));
                    end
                    ip = 0;
                end else if (owner == 2) begin
                    if (!o_we) begin
                        total++;
                        if (bus.data_rdata_o !== mem_val(o_addr)) begin
                            bad++; $display("FAIL rand_load_data: got %h want %h", bus.data_rdata_o, mem_val(o_addr));
                        end
                    end
                    dp = 0;
                end
                owner = 0;
            end
            if (bus.mem_ce_o && !ce_prev) begin
                exp_win = (ip && streak == 4) ? 1 : dp ? 2 : ip ? 1 : 0;
                total++;
                if (exp_win == 1) begin
                    if ({bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o} !== {ia, 1'b0, 32'd0}) begin
                        bad++; $display("FAIL rand_grant_inst: got %h/%b/%h want %h/0/0",
                                        bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o, ia);
                    end
                    streak = 0; gi++;
                    o_addr = ia; o_we = 0; o_wd = 0;
                end else if (exp_win == 2) begin
                    if ({bus.mem_addr_o, bus.mem_we_o} !== {da, dwe} ||
                        (dwe && bus.mem_wdata_o !== dwd)) begin
                        bad++; $display("FAIL rand_grant_data: got %h/%b/%h want %h/%b/%h",
                                        bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o, da, dwe, dwd);
                    end
                    streak = ip ? ((streak < 4) ? streak + 1 : 4) : 0;
                    gd++;
                    o_addr = da; o_we = dwe; o_wd = dwd;
                end else begin
                    bad++; $display("FAIL rand_spurious_grant: got ce=1 want 0");
                end
                owner = exp_win;
            end
            // memory model: random wait states, never long enough to time out
            rdy = 1'b0;
            if (bus.mem_ce_o) begin
                waitc++;
                rdy = (waitc >= 5) || ($urandom_range(0, 2) != 0);
                if (rdy) begin
                    if (bus.mem_we_o) shadow[bus.mem_addr_o] = bus.mem_wdata_o;
                    else bus.mem_rdata_i = mem_val(bus.mem_addr_o);
                    waitc = 0;
                end
            end else begin
                waitc = 0;
                bus.mem_rdata_i = $urandom;
            end
            bus.mem_ready_i = rdy;
            rdy_prev = rdy && bus.mem_ce_o;
            // requesters
            if (!ip && cyc < 1450 && $urandom_range(0, 2) == 0) begin
                ip = 1;
                ia = 32'($urandom_range(0, 255)) << 2;
            end
            if (!dp && cyc < 1450 && $urandom_range(0, 2) == 0) begin
                dp  = 1;
                dwe = 1'($urandom_range(0, 1));
                da  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
                dwd = $urandom;
            end
            bus.inst_req_i   = ip;
            bus.inst_addr_i  = ia;
            bus.data_req_i   = dp;
            bus.data_we_i    = dwe;
            bus.data_addr_i  = da;
            bus.data_wdata_i = dwd;
            ce_prev = bus.mem_ce_o;
        end
        total++;
        if (gi == 0 || gd == 0 || owner != 0) begin
            bad++; $display("FAIL rand_coverage: got fetch=%0d data=%0d owner=%0d want both >0, owner 0", gi, gd, owner);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store();
        test_priority();
        test_timeout();
        test_reset_mid_access();
        test_req_drop();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1);
    end

endmodule
